// File: rtl/rv_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_decode_stage                                                          |
// | RV32/RV64 base-ISA decode: format + sign-extended immediate, skid output |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rv_decode_stage #(
   parameter int XLEN      = 32,
   parameter bit BYTE_SWAP = 1'b1,
   parameter bit SKID      = 1'b1
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_data_i,
   input  logic [XLEN-1:0] in_pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_pc_o,
   output logic [6:0]      opcode_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [2:0]      funct3_o,
   output logic [6:0]      funct7_o,
   output logic [2:0]      fmt_o,
   output logic [XLEN-1:0] imm_o,
   output logic            illegal_o,
   output logic [31:0]     instr_cnt_o
);

   localparam logic [2:0] c_FMT_R = 3'd0;
   localparam logic [2:0] c_FMT_I = 3'd1;
   localparam logic [2:0] c_FMT_S = 3'd2;
   localparam logic [2:0] c_FMT_B = 3'd3;
   localparam logic [2:0] c_FMT_U = 3'd4;
   localparam logic [2:0] c_FMT_J = 3'd5;
   localparam logic [2:0] c_FMT_X = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [2:0]      fmt;
      logic [XLEN-1:0] imm;
   } entry_t;

   logic [31:0] w_instr;
   logic [2:0]  w_fmt;
   logic [31:0] w_imm32;
   entry_t      w_dec;
   entry_t      r_out;
   logic        r_out_valid;
   logic [31:0] r_cnt;
   logic        w_out_hs;

   always_comb begin
      w_instr = BYTE_SWAP ? {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]}
                          : in_data_i;
      w_fmt   = c_FMT_X;
      if (w_instr[1:0] == 2'b11) begin
         case (w_instr[6:0])
            7'b0110011: w_fmt = c_FMT_R;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: w_fmt = c_FMT_I;
            7'b0100011: w_fmt = c_FMT_S;
            7'b1100011: w_fmt = c_FMT_B;
            7'b0110111,
            7'b0010111: w_fmt = c_FMT_U;
            7'b1101111: w_fmt = c_FMT_J;
            7'b0111011: w_fmt = (XLEN == 64) ? c_FMT_R : c_FMT_X;
            7'b0011011: w_fmt = (XLEN == 64) ? c_FMT_I : c_FMT_X;
            default:    w_fmt = c_FMT_X;
         endcase
      end

      case (w_fmt)
         c_FMT_I: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         c_FMT_S: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         c_FMT_B: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                             w_instr[11:8], 1'b0};
         c_FMT_U: w_imm32 = {w_instr[31:12], 12'b0};
         c_FMT_J: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                             w_instr[30:21], 1'b0};
         default: w_imm32 = 32'b0;
      endcase

      // All 32-bit immediates are already sign-correct; widen arithmetically for RV64.
      w_dec       = '0;
      w_dec.pc    = in_pc_i;
      w_dec.instr = w_instr;
      w_dec.fmt   = w_fmt;
      w_dec.imm   = XLEN'($signed(w_imm32));
   end

   generate
      if (SKID) begin : g_skid
         typedef enum logic [1:0] {
            S_EMPTY = 2'd0,
            S_FULL1 = 2'd1,
            S_FULL2 = 2'd2
         } state_t;

         state_t r_state;
         entry_t r_skid;
         logic   r_in_ready;

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               r_state     <= S_EMPTY;
               r_out       <= '0;
               r_skid      <= '0;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end else if (flush_i) begin
               r_state     <= S_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end else begin
               case (r_state)
                  S_EMPTY: begin
                     if (in_valid_i) begin
                        r_out       <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= S_FULL1;
                     end
                  end
                  S_FULL1: begin
                     if (in_valid_i && out_ready_i) begin
                        r_out <= w_dec;
                     end else if (in_valid_i) begin
                        r_skid     <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL2;
                     end else if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                     end
                  end
                  S_FULL2: begin
                     if (out_ready_i) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= S_FULL1;
                     end
                  end
                  default: begin
                     r_state     <= S_EMPTY;
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                  end
               endcase
            end
         end

         assign in_ready_o = r_in_ready;
      end else begin : g_noskid
         assign in_ready_o = !r_out_valid || out_ready_i;

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               r_out       <= '0;
               r_out_valid <= 1'b0;
            end else if (flush_i) begin
               r_out_valid <= 1'b0;
            end else if (in_valid_i && in_ready_o) begin
               r_out       <= w_dec;
               r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   endgenerate

   // A flushed cycle discards the output handshake, so it is not retired.
   assign w_out_hs = r_out_valid && out_ready_i && !flush_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cnt <= 32'd0;
      end else if (w_out_hs) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign out_valid_o = r_out_valid;
   assign out_pc_o    = r_out.pc;
   assign opcode_o    = r_out.instr[6:0];
   assign rd_o        = r_out.instr[11:7];
   assign funct3_o    = r_out.instr[14:12];
   assign rs1_o       = r_out.instr[19:15];
   assign rs2_o       = r_out.instr[24:20];
   assign funct7_o    = r_out.instr[31:25];
   assign fmt_o       = r_out.fmt;
   assign imm_o       = r_out.imm;
   assign illegal_o   = (r_out.fmt == c_FMT_X);
   assign instr_cnt_o = r_cnt;

endmodule
`default_nettype wire
